// File: rtl/step_control_fsm_pkg.sv
// step_ctrl_pkg: shared types and constants for the stepper-motor control unit.
//   opcode_e   : 4-bit instruction opcodes (12..15 are illegal)
//   state_e    : control FSM states
//   OP1_* / WA_* : datapath mux-select encodings
package step_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_BR     = 4'd0,
    OP_BRZ    = 4'd1,
    OP_ADDI   = 4'd2,
    OP_SUBI   = 4'd3,
    OP_SR0    = 4'd4,
    OP_SRH0   = 4'd5,
    OP_CLR    = 4'd6,
    OP_MOV    = 4'd7,
    OP_MOVA   = 4'd8,
    OP_MOVR   = 4'd9,
    OP_MOVRHS = 4'd10,
    OP_PAUSE  = 4'd11
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MOVR_LOAD,
    S_MOVR_STEP,
    S_SDLY_START,
    S_SDLY_WAIT,
    S_PAUSE_START,
    S_PAUSE_WAIT,
    S_HALT
  } state_e;

  localparam logic [1:0] OP1_PC   = 2'd0;
  localparam logic [1:0] OP1_REG  = 2'd1;
  localparam logic [1:0] OP1_TEMP = 2'd2;

  localparam logic [1:0] WA_R0 = 2'd1;
  localparam logic [1:0] WA_R1 = 2'd2;
  localparam logic [1:0] WA_RT = 2'd3;

  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd12;

endpackage

// File: rtl/step_control_fsm_if.sv
// Instruction-fetch handshake between the control unit and instruction memory.
//   mem_req : control unit requests the next instruction word
//   load_ir : control unit captures the word into IR (same cycle as mem_ack)
//   mem_ack : memory has the word on the IR input
//   opcode  : IR opcode field, valid the cycle after load_ir
interface step_control_fsm_if;
  logic       mem_req;
  logic       load_ir;
  logic       mem_ack;
  logic [3:0] opcode;

  modport master (output mem_req, load_ir, input mem_ack, opcode);
  modport slave  (input mem_req, load_ir, output mem_ack, opcode);
endinterface

// File: rtl/step_control_fsm.sv
// step_control_fsm: multi-cycle control unit for the stepper-motor datapath.
// Fetches through the fetch interface, decodes, then sequences single-cycle
// ops, the MOVR/MOVRHS step loop (optionally paced by the delay counter),
// PAUSE and illegal-opcode trapping.
//   clk, reset_n          : clock, async active-low reset
//   fetch                 : fetch handshake (master side)
//   run/single_step/step_req : execution control
//   register0_is_zero, temp_is_*, delay_done : datapath status
//   remaining outputs     : datapath control strobes and mux selects
//
// state        | meaning
// IDLE         | stopped, waiting for run / step_req
// FETCH        | mem_req until mem_ack, load_ir on ack
// DECODE       | opcode latched into op_q, routed
// EXEC         | one-cycle instruction (and NOP for illegal ops)
// MOVR_LOAD    | load temp register with the step count
// MOVR_STEP    | one step per cycle until temp is zero
// SDLY_START   | start delay counter between steps
// SDLY_WAIT    | wait for delay_done, then next step
// PAUSE_START  | start delay counter for PAUSE
// PAUSE_WAIT   | wait for delay_done, then retire PAUSE
// HALT         | illegal opcode trap, left only by reset
module step_control_fsm
  import step_ctrl_pkg::*;
#(
  parameter bit STEP_DELAY      = 1'b0,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  step_control_fsm_if.master         fetch,
  input  logic                       run,
  input  logic                       single_step,
  input  logic                       step_req,
  input  logic                       register0_is_zero,
  input  logic                       temp_is_positive,
  input  logic                       temp_is_negative,
  input  logic                       temp_is_zero,
  input  logic                       delay_done,
  output logic                       write_reg_file,
  output logic                       result_mux_select,
  output logic                       start_delay_counter,
  output logic                       enable_delay_counter,
  output logic                       commit_branch,
  output logic                       increment_pc,
  output logic                       alu_add_sub,
  output logic                       alu_set_low,
  output logic                       alu_set_high,
  output logic                       load_temp_register,
  output logic                       increment_temp_register,
  output logic                       decrement_temp_register,
  output logic [1:0]                 op1_mux_select,
  output logic [1:0]                 op2_mux_select,
  output logic [1:0]                 select_immediate,
  output logic [1:0]                 select_write_address,
  output logic                       halted,
  output logic                       illegal_op
);

  state_e     state, state_nxt;
  logic [3:0] op_q;
  logic       mem_req_c, load_ir_c;
  state_e     exit_state;

  assign fetch.mem_req = mem_req_c;
  assign fetch.load_ir = load_ir_c;

  // Where a completed instruction goes: stop if run dropped or stepping.
  assign exit_state = (!run || single_step) ? S_IDLE : S_FETCH;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op_q <= fetch.opcode;
    end
  end

  always_comb begin
    state_nxt               = state;
    mem_req_c               = 1'b0;
    load_ir_c               = 1'b0;
    write_reg_file          = 1'b0;
    result_mux_select       = 1'b0;
    start_delay_counter     = 1'b0;
    enable_delay_counter    = 1'b0;
    commit_branch           = 1'b0;
    increment_pc            = 1'b0;
    alu_add_sub             = 1'b0;
    alu_set_low             = 1'b0;
    alu_set_high            = 1'b0;
    load_temp_register      = 1'b0;
    increment_temp_register = 1'b0;
    decrement_temp_register = 1'b0;
    op1_mux_select          = 2'd0;
    op2_mux_select          = 2'd0;
    select_immediate        = 2'd0;
    select_write_address    = 2'd0;
    halted                  = 1'b0;
    illegal_op              = 1'b0;

    case (state)
      S_IDLE: begin
        if (run && (!single_step || step_req)) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (fetch.mem_ack) begin
          load_ir_c = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (fetch.opcode == OP_MOVR || fetch.opcode == OP_MOVRHS) state_nxt = S_MOVR_LOAD;
        else if (fetch.opcode == OP_PAUSE)                        state_nxt = S_PAUSE_START;
        else if (fetch.opcode >= OP_ILLEGAL_MIN)                  state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_EXEC;
        else                                                      state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = exit_state;
        case (op_q)
          OP_BR, OP_BRZ: begin
            // BRZ not taken falls through to a plain PC increment.
            if (op_q == OP_BR || register0_is_zero) begin
              select_immediate = 2'd2;
              op1_mux_select   = OP1_PC;
              op2_mux_select   = 2'd1;
              alu_add_sub      = 1'b1;
              commit_branch    = 1'b1;
            end else begin
              increment_pc = 1'b1;
            end
          end
          OP_ADDI, OP_SUBI, OP_SR0, OP_SRH0: begin
            select_immediate     = (op_q == OP_SR0 || op_q == OP_SRH0) ? 2'd1 : 2'd0;
            op1_mux_select       = OP1_REG;
            op2_mux_select       = 2'd1;
            alu_add_sub          = (op_q == OP_ADDI);
            alu_set_low          = (op_q == OP_SR0);
            alu_set_high         = (op_q == OP_SRH0);
            select_write_address = WA_R0;
            write_reg_file       = 1'b1;
            increment_pc         = 1'b1;
          end
          OP_CLR: begin
            result_mux_select    = 1'b1;
            select_write_address = WA_R0;
            write_reg_file       = 1'b1;
            increment_pc         = 1'b1;
          end
          OP_MOV, OP_MOVA: begin
            select_immediate     = (op_q == OP_MOVA) ? 2'd3 : 2'd0;
            op1_mux_select       = OP1_REG;
            op2_mux_select       = (op_q == OP_MOVA) ? 2'd1 : 2'd0;
            select_write_address = WA_R1;
            write_reg_file       = 1'b1;
            increment_pc         = 1'b1;
          end
          default: increment_pc = 1'b1;  // illegal ops as NOP
        endcase
      end
      S_MOVR_LOAD: begin
        load_temp_register = 1'b1;
        state_nxt          = S_MOVR_STEP;
      end
      S_MOVR_STEP: begin
        if (temp_is_zero) begin
          increment_pc = 1'b1;
          state_nxt    = exit_state;
        end else if (temp_is_positive || temp_is_negative) begin
          write_reg_file          = 1'b1;
          select_write_address    = WA_RT;
          op1_mux_select          = OP1_TEMP;
          op2_mux_select          = (op_q == OP_MOVRHS) ? 2'd2 : 2'd3;
          alu_add_sub             = temp_is_positive;
          decrement_temp_register = temp_is_positive;
          increment_temp_register = !temp_is_positive;
          if (STEP_DELAY) state_nxt = S_SDLY_START;
        end
      end
      S_SDLY_START: begin
        start_delay_counter = 1'b1;
        state_nxt           = S_SDLY_WAIT;
      end
      S_SDLY_WAIT: begin
        enable_delay_counter = 1'b1;
        if (delay_done) state_nxt = S_MOVR_STEP;
      end
      S_PAUSE_START: begin
        start_delay_counter = 1'b1;
        state_nxt           = S_PAUSE_WAIT;
      end
      S_PAUSE_WAIT: begin
        enable_delay_counter = 1'b1;
        if (delay_done) begin
          increment_pc = 1'b1;
          state_nxt    = exit_state;
        end
      end
      S_HALT: begin
        halted     = 1'b1;
        illegal_op = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
